// File: rtl/io_in_filter.sv
// io_in_filter: sample strobe for the upstream input registers, resync of their Q, per-bit debounce.
// Latency: D change to Q/RISE/FALL is SYNC_STAGES + STABLE_COUNT clocks at PRESCALE=1 (scales with strobe cadence).
// Backpressure: none; free-running pipeline, EN only gates the sample strobe (ticks in flight still land).
module io_in_filter #(
    parameter int               WIDTH        = 4,
    parameter int               SYNC_STAGES  = 2,
    parameter int               PRESCALE     = 1,
    parameter int               STABLE_COUNT = 4,
    parameter logic [WIDTH-1:0] RESET_VALUE  = '0
) (
    input  logic             CLK,
    input  logic             RSTN,
    input  logic             EN,
    input  logic [WIDTH-1:0] D,
    output logic             SP,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] RISE,
    output logic [WIDTH-1:0] FALL,
    output logic             CHANGED
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int CW = (STABLE_COUNT > 1) ? $clog2(STABLE_COUNT) : 1;
    localparam logic [PW-1:0] PRE_LAST    = PW'(PRESCALE - 1);
    localparam logic [CW-1:0] STABLE_LAST = CW'(STABLE_COUNT - 1);

    logic [PW-1:0]          pre_cnt;
    logic [WIDTH-1:0]       sync_q [SYNC_STAGES];
    logic [SYNC_STAGES:0]   tick_pipe;
    logic [WIDTH-1:0]       s_lvl;
    logic                   tick;

    logic [CW-1:0]          cnt_q [WIDTH];
    logic [CW-1:0]          cnt_d [WIDTH];
    logic [WIDTH-1:0]       q_d;
    logic [WIDTH-1:0]       rise_d;
    logic [WIDTH-1:0]       fall_d;

    assign s_lvl = sync_q[SYNC_STAGES-1];
    assign tick  = tick_pipe[SYNC_STAGES];

    // Prescaler: one-cycle SP every PRESCALE enabled clocks; dropping EN restarts the cadence.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            pre_cnt <= '0;
            SP      <= 1'b0;
        end else if (EN) begin
            SP      <= (pre_cnt == PRE_LAST);
            pre_cnt <= (pre_cnt == PRE_LAST) ? '0 : pre_cnt + 1'b1;
        end else begin
            pre_cnt <= '0;
            SP      <= 1'b0;
        end
    end

    // Resync chain on the I/O register outputs; shifts every clock independent of EN.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            for (int j = 0; j < SYNC_STAGES; j++) begin
                sync_q[j] <= RESET_VALUE;
            end
        end else begin
            sync_q[0] <= D;
            for (int j = 1; j < SYNC_STAGES; j++) begin
                sync_q[j] <= sync_q[j-1];
            end
        end
    end

    // Delay SP so tick lines up with the first cycle the strobed sample is visible at s_lvl.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            tick_pipe <= '0;
        end else begin
            tick_pipe <= {tick_pipe[SYNC_STAGES-1:0], SP};
        end
    end

    // Per-bit stability counters: count consecutive differing ticks, toggle Q on the last one.
    always_comb begin
        q_d    = Q;
        rise_d = '0;
        fall_d = '0;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i] = cnt_q[i];
        end
        if (tick) begin
            for (int i = 0; i < WIDTH; i++) begin
                if (s_lvl[i] == Q[i]) begin
                    cnt_d[i] = '0;
                end else if (cnt_q[i] != STABLE_LAST) begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end else begin
                    cnt_d[i]  = '0;
                    q_d[i]    = ~Q[i];
                    rise_d[i] = ~Q[i];
                    fall_d[i] = Q[i];
                end
            end
        end
    end

    // Filter state and registered level/edge outputs; reset drops any partial count silently.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            Q       <= RESET_VALUE;
            RISE    <= '0;
            FALL    <= '0;
            CHANGED <= 1'b0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            Q       <= q_d;
            RISE    <= rise_d;
            FALL    <= fall_d;
            CHANGED <= |(rise_d | fall_d);
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

endmodule

// File: tb/tb_io_in_filter.sv
module tb_io_in_filter;

    localparam int W  = 4;
    localparam int SS = 2;
    localparam int SC = 4;
    localparam logic [W-1:0] RV = 4'h0;

    logic         clk = 1'b0;
    logic         rstn;
    logic         en;
    logic [W-1:0] d;

    logic         sp_a, chg_a, sp_b, chg_b;
    logic [W-1:0] q_a, rise_a, fall_a, q_b, rise_b, fall_b;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    io_in_filter #(.WIDTH(W), .SYNC_STAGES(SS), .PRESCALE(1), .STABLE_COUNT(SC), .RESET_VALUE(RV)) dut_a (
        .CLK(clk), .RSTN(rstn), .EN(en), .D(d),
        .SP(sp_a), .Q(q_a), .RISE(rise_a), .FALL(fall_a), .CHANGED(chg_a)
    );

    io_in_filter #(.WIDTH(W), .SYNC_STAGES(SS), .PRESCALE(5), .STABLE_COUNT(SC), .RESET_VALUE(RV)) dut_b (
        .CLK(clk), .RSTN(rstn), .EN(en), .D(d),
        .SP(sp_b), .Q(q_b), .RISE(rise_b), .FALL(fall_b), .CHANGED(chg_b)
    );

    // Reference model: history of sampled D and of strobes, plus a run-length of stable differing ticks.
    logic [W-1:0] m_q [2];
    logic [W-1:0] m_rise [2];
    logic [W-1:0] m_fall [2];
    logic         m_sp [2];
    int           m_run [2];
    int           m_cnt [2][W];
    logic [W-1:0] m_dh [SS];
    logic         m_sph [2][SS+2];

    function automatic int pscale(int k);
        return (k == 0) ? 1 : 5;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_q[k] = RV; m_rise[k] = '0; m_fall[k] = '0; m_sp[k] = 1'b0; m_run[k] = 0;
            for (int i = 0; i < W; i++) m_cnt[k][i] = 0;
            for (int j = 0; j < SS + 2; j++) m_sph[k][j] = 1'b0;
        end
        for (int j = 0; j < SS; j++) m_dh[j] = RV;
    endtask

    task automatic model_edge();
        logic [W-1:0] s;
        logic t;
        s = m_dh[SS-1];
        for (int k = 0; k < 2; k++) begin
            t = m_sph[k][SS+1];
            m_rise[k] = '0;
            m_fall[k] = '0;
            if (t) begin
                for (int i = 0; i < W; i++) begin
                    if (s[i] == m_q[k][i]) m_cnt[k][i] = 0;
                    else if (m_cnt[k][i] < SC - 1) m_cnt[k][i]++;
                    else begin
                        m_cnt[k][i] = 0;
                        m_q[k][i] = ~m_q[k][i];
                        if (m_q[k][i]) m_rise[k][i] = 1'b1;
                        else m_fall[k][i] = 1'b1;
                    end
                end
            end
            m_run[k] = en ? m_run[k] + 1 : 0;
            m_sp[k] = en && (m_run[k] % pscale(k) == 0);
            for (int j = SS + 1; j > 0; j--) m_sph[k][j] = m_sph[k][j-1];
            m_sph[k][0] = m_sp[k];
        end
        for (int j = SS - 1; j > 0; j--) m_dh[j] = m_dh[j-1];
        m_dh[0] = d;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (rstn) model_edge();
    endtask

    function automatic logic [27:0] obs_vec();
        return {sp_a, q_a, rise_a, fall_a, chg_a, sp_b, q_b, rise_b, fall_b, chg_b};
    endfunction

    function automatic logic [27:0] exp_vec();
        return {m_sp[0], m_q[0], m_rise[0], m_fall[0], |(m_rise[0] | m_fall[0]),
                m_sp[1], m_q[1], m_rise[1], m_fall[1], |(m_rise[1] | m_fall[1])};
    endfunction

    task automatic test_reset();
        rstn = 1'b0; en = 1'b1; d = 4'hF;
        model_reset();
        repeat (3) step();
        n_checks++;
        if ({q_a, sp_a, rise_a, fall_a, chg_a, q_b, sp_b, rise_b, fall_b, chg_b} !== {RV, 10'b0, RV, 10'b0})
            $display("FAIL reset_state: got %h expected %h", {q_a, sp_a, rise_a, fall_a, chg_a, q_b, sp_b, rise_b, fall_b, chg_b}, {RV, 10'b0, RV, 10'b0});
        else n_pass++;
        d = 4'h0; rstn = 1'b1;
        for (int e = 0; e < 4; e++) begin
            step();
            n_checks++;
            if ({rise_a, fall_a, chg_a, rise_b, fall_b, chg_b} !== 18'b0)
                $display("FAIL reset_release_pulse: got %h expected 0", {rise_a, fall_a, chg_a, rise_b, fall_b, chg_b});
            else n_pass++;
            n_checks++;
            if (obs_vec() !== exp_vec()) $display("FAIL reset_release_model: got %h expected %h", obs_vec(), exp_vec());
            else n_pass++;
        end
    endtask

    task automatic test_latency();
        logic eq, er;
        d = 4'h0;
        repeat (8) step();
        d[0] = 1'b1;
        for (int e = 1; e <= 7; e++) begin
            step();
            eq = (e >= 6);
            er = (e == 6);
            n_checks++;
            if ({q_a[0], rise_a[0], chg_a} !== {eq, er, er})
                $display("FAIL latency_e%0d: got q/rise/chg %b expected %b", e, {q_a[0], rise_a[0], chg_a}, {eq, er, er});
            else n_pass++;
            n_checks++;
            if (obs_vec() !== exp_vec()) $display("FAIL latency_model: got %h expected %h", obs_vec(), exp_vec());
            else n_pass++;
        end
    endtask

    task automatic test_glitch();
        int rises = 0;
        d[1] = 1'b1;
        repeat (3) begin step(); if (rise_a[1]) rises++; end
        d[1] = 1'b0;
        repeat (12) begin step(); if (rise_a[1]) rises++; end
        n_checks++;
        if ({q_a[1], rises[3:0]} !== 5'b0) $display("FAIL glitch_reject: got q=%b rises=%0d expected q=0 rises=0", q_a[1], rises);
        else n_pass++;
        d[1] = 1'b1;
        for (int e = 0; e < 12; e++) begin
            if (e == 4) d[1] = 1'b0;
            step();
            if (rise_a[1]) rises++;
            n_checks++;
            if (obs_vec() !== exp_vec()) $display("FAIL glitch_model: got %h expected %h", obs_vec(), exp_vec());
            else n_pass++;
        end
        n_checks++;
        if (rises != 1) $display("FAIL glitch_accept: got rises=%0d expected 1", rises);
        else n_pass++;
    endtask

    task automatic wait_sp_b(input string name);
        logic found = 1'b0;
        for (int i = 0; i < 12 && !found; i++) begin
            step();
            if (sp_b) found = 1'b1;
        end
        n_checks++;
        if (found !== 1'b1) $display("FAIL %s_sp_timeout: got no SP expected SP within 12 cycles", name);
        else n_pass++;
    endtask

    task automatic test_prescale();
        int last = 0, highs = 0;
        logic old_v;
        en = 1'b1;
        wait_sp_b("prescale");
        for (int e = 1; e <= 25; e++) begin
            step();
            if (sp_b) begin
                n_checks++;
                if (e - last != 5) $display("FAIL prescale_gap: got %0d expected 5", e - last);
                else n_pass++;
                last = e; highs++;
            end
        end
        n_checks++;
        if (highs != 5) $display("FAIL prescale_count: got %0d expected 5", highs);
        else n_pass++;
        wait_sp_b("prescale_step");
        old_v = m_q[1][2];
        d[2] = ~old_v;
        for (int e = 1; e <= 22; e++) begin
            step();
            n_checks++;
            if (q_b[2] !== ((e >= 19) ? ~old_v : old_v))
                $display("FAIL prescale_latency_e%0d: got %b expected %b", e, q_b[2], (e >= 19) ? ~old_v : old_v);
            else n_pass++;
            n_checks++;
            if (obs_vec() !== exp_vec()) $display("FAIL prescale_model: got %h expected %h", obs_vec(), exp_vec());
            else n_pass++;
        end
    endtask

    task automatic test_en_gating();
        logic old_v;
        wait_sp_b("en_gating");
        old_v = m_q[1][3];
        d[3] = ~old_v;
        repeat (9) step();
        en = 1'b0;
        for (int e = 0; e < 10; e++) begin
            step();
            n_checks++;
            if ({sp_b, q_b[3]} !== {1'b0, old_v}) $display("FAIL en_gated: got sp/q %b expected %b", {sp_b, q_b[3]}, {1'b0, old_v});
            else n_pass++;
        end
        en = 1'b1;
        for (int e = 1; e <= 16; e++) begin
            step();
            n_checks++;
            if (q_b[3] !== ((e >= 14) ? ~old_v : old_v))
                $display("FAIL en_resume_e%0d: got %b expected %b", e, q_b[3], (e >= 14) ? ~old_v : old_v);
            else n_pass++;
            n_checks++;
            if (obs_vec() !== exp_vec()) $display("FAIL en_model: got %h expected %h", obs_vec(), exp_vec());
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid();
        d = 4'h0;
        repeat (12) step();
        d[0] = 1'b1;
        repeat (5) step();
        n_checks++;
        if ({q_a[0], rise_a[0]} !== 2'b00) $display("FAIL midreset_pre: got %b expected 00", {q_a[0], rise_a[0]});
        else n_pass++;
        #2 rstn = 1'b0;
        #1 model_reset();
        n_checks++;
        if ({q_a, rise_a, sp_a, q_b} !== {RV, 4'h0, 1'b0, RV})
            $display("FAIL midreset_async: got %h expected %h", {q_a, rise_a, sp_a, q_b}, {RV, 4'h0, 1'b0, RV});
        else n_pass++;
        repeat (3) step();
        d = 4'h0; rstn = 1'b1;
        for (int e = 0; e < 10; e++) begin
            step();
            n_checks++;
            if ({rise_a, chg_a} !== 5'b0) $display("FAIL midreset_pulse: got %b expected 0", {rise_a, chg_a});
            else n_pass++;
            n_checks++;
            if (obs_vec() !== exp_vec()) $display("FAIL midreset_model: got %h expected %h", obs_vec(), exp_vec());
            else n_pass++;
        end
    endtask

    task automatic test_random();
        for (int e = 0; e < 600; e++) begin
            d  = d ^ (W'($urandom) & W'($urandom) & W'($urandom));
            en = ($urandom_range(0, 9) != 0);
            step();
            n_checks++;
            if (obs_vec() !== exp_vec()) $display("FAIL random_c%0d: got %h expected %h", e, obs_vec(), exp_vec());
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_glitch();
        test_prescale();
        test_en_gating();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
